sr_fetch: RTL and testbench

//  Instruction fetch stage feeding sr_decode. Owns the PC, issues in-order word requests to a

---
 rtl/sr_fetch.sv | 117 +++++++++++
 tb/tb_sr_fetch.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sr_fetch.sv
// Instruction fetch stage: owns the PC, issues in-order word requests to imem, and buffers returned
// words in a DEPTH-entry FIFO for sr_decode. Optional counters via `define SR_FETCH_PERF_EN.
module sr_fetch #(
    parameter int          DEPTH    = 2,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc
`ifdef SR_FETCH_PERF_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_dropped
`endif
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW+1:0] DEPTH_W = (CW+2)'(DEPTH);

    logic [31:0]   pc;
    logic [31:0]   rsp_pc;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] drop_cnt;
    logic [CW-1:0] fifo_count;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [63:0]   fifo_mem [DEPTH];

    logic [CW+1:0] committed;
    logic          req_fire;
    logic          rsp_live;
    logic          rsp_drop;
    logic          push;
    logic          pop;

    // Every word in flight, buffered, or still to be discarded holds a FIFO slot,
    // so a response can always be accepted without backpressure.
    assign committed = {2'b00, outstanding} + {2'b00, fifo_count} + {2'b00, drop_cnt};

    assign imem_req_valid = !rst && !redirect_valid && (committed < DEPTH_W);
    assign imem_req_addr  = pc;
    assign req_fire       = imem_req_valid && imem_req_ready;

    assign rsp_live = imem_rsp_valid && !rst;
    assign rsp_drop = rsp_live && (redirect_valid || (drop_cnt != '0));
    assign push     = rsp_live && !redirect_valid && (drop_cnt == '0);

    assign instr_valid = !rst && !redirect_valid && (fifo_count != '0);
    assign pop         = instr_valid && instr_ready;
    assign instr       = fifo_mem[rd_ptr][63:32];
    assign instr_pc    = fifo_mem[rd_ptr][31:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            pc          <= RESET_PC;
            rsp_pc      <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
            fifo_count  <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
        end else if (redirect_valid) begin
            pc          <= {redirect_pc[31:2], 2'b00};
            rsp_pc      <= {redirect_pc[31:2], 2'b00};
            // Anything still owed by imem is now stale; a response landing this cycle settles one of them.
            drop_cnt    <= drop_cnt + outstanding - CW'(rsp_live);
            outstanding <= '0;
            fifo_count  <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
        end else begin
            if (req_fire)
                pc <= pc + 32'd4;
            if (push) begin
                rsp_pc <= rsp_pc + 32'd4;
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (rsp_drop)
                drop_cnt <= drop_cnt - 1'b1;
            outstanding <= outstanding + CW'(req_fire) - CW'(push);
            fifo_count  <= fifo_count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            fifo_mem[wr_ptr] <= {imem_rsp_data, rsp_pc};
    end

`ifdef SR_FETCH_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetched <= '0;
            perf_dropped <= '0;
        end else begin
            if (pop)
                perf_fetched <= perf_fetched + 32'd1;
            perf_dropped <= perf_dropped + 32'(rsp_drop)
                            + (redirect_valid ? 32'(fifo_count) : 32'd0);
        end
    end
`endif

endmodule

// File: tb/tb_sr_fetch.sv
// Directed bench for sr_fetch (DEPTH=2) with a fixed-latency, in-order imem model.
// Memory returns the bitwise inverse of the request address as the instruction word.
module tb_sr_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
`ifdef SR_FETCH_PERF_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_dropped;
`endif

    int checks = 0;
    int errors = 0;

    logic [2:0]  lat_idx = 3'd0;
    logic [7:0]  sv = 8'h00;
    logic [31:0] sa [8];

    always #5 clk = ~clk;

    sr_fetch #(.DEPTH(2), .RESET_PC(32'h0)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .instr_pc       (instr_pc)
`ifdef SR_FETCH_PERF_EN
        ,
        .perf_fetched   (perf_fetched),
        .perf_dropped   (perf_dropped)
`endif
    );

    // imem: response appears lat_idx+1 cycles after the accepting edge
    always @(posedge clk) begin
        if (rst) begin
            sv <= 8'h00;
        end else begin
            sv    <= {sv[6:0], imem_req_valid & imem_req_ready};
            sa[0] <= imem_req_addr;
            for (int i = 1; i < 8; i++) sa[i] <= sa[i-1];
        end
    end
    assign imem_rsp_valid = sv[lat_idx];
    assign imem_rsp_data  = ~sa[lat_idx];

    task automatic do_reset(input int lat);
        @(negedge clk);
        rst = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0;
        instr_ready = 1'b0; imem_req_ready = 1'b1; lat_idx = 3'(lat - 1);
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0;
        instr_ready = 1'b1; imem_req_ready = 1'b1; lat_idx = 3'd0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (imem_req_valid !== 1'b0) begin
                errors++; $display("FAIL reset_req_valid cycle %0d got %b want 0", i, imem_req_valid);
            end
            checks++;
            if (instr_valid !== 1'b0) begin
                errors++; $display("FAIL reset_instr_valid cycle %0d got %b want 0", i, instr_valid);
            end
            @(negedge clk);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin
            errors++; $display("FAIL first_req got v=%b a=%h want v=1 a=00000000", imem_req_valid, imem_req_addr);
        end
        checks++;
        if (instr_valid !== 1'b0) begin
            errors++; $display("FAIL post_reset_empty got %b want 0", instr_valid);
        end
    endtask

    task automatic test_stream();
        logic [31:0] exp_pc;
        int n, first;
        do_reset(1);
        instr_ready = 1'b1;
        exp_pc = 32'h0; n = 0; first = -1;
        for (int i = 0; i < 60 && n < 8; i++) begin
            #1;
            if (instr_valid) begin
                if (first < 0) first = i;
                checks++;
                if (instr_pc !== exp_pc || instr !== ~exp_pc) begin
                    errors++; $display("FAIL stream_word got pc=%h d=%h want pc=%h d=%h", instr_pc, instr, exp_pc, ~exp_pc);
                end
                exp_pc += 32'd4; n++;
            end
            @(negedge clk);
        end
        checks++;
        if (n != 8) begin
            errors++; $display("FAIL stream_count got %0d want 8", n);
        end
        checks++;
        if (first != 2) begin
            errors++; $display("FAIL stream_latency got %0d want 2", first);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] exp_pc;
        int acc, n;
        do_reset(1);
        acc = 0;
        for (int i = 0; i < 10; i++) begin
            #1;
            if (imem_req_valid && imem_req_ready) acc++;
            if (i >= 4) begin
                checks++;
                if (instr_valid !== 1'b1 || instr_pc !== 32'h0 || instr !== 32'hFFFF_FFFF) begin
                    errors++; $display("FAIL bp_head_stable got v=%b pc=%h d=%h want v=1 pc=00000000 d=ffffffff", instr_valid, instr_pc, instr);
                end
            end
            @(negedge clk);
        end
        #1;
        checks++;
        if (acc != 2) begin
            errors++; $display("FAIL bp_accepted got %0d want 2", acc);
        end
        checks++;
        if (imem_req_valid !== 1'b0) begin
            errors++; $display("FAIL bp_req_blocked got %b want 0", imem_req_valid);
        end
        instr_ready = 1'b1;
        exp_pc = 32'h0; n = 0;
        for (int i = 0; i < 40 && n < 6; i++) begin
            #1;
            if (instr_valid) begin
                checks++;
                if (instr_pc !== exp_pc || instr !== ~exp_pc) begin
                    errors++; $display("FAIL bp_drain got pc=%h d=%h want pc=%h d=%h", instr_pc, instr, exp_pc, ~exp_pc);
                end
                exp_pc += 32'd4; n++;
            end
            @(negedge clk);
        end
        checks++;
        if (n != 6) begin
            errors++; $display("FAIL bp_drain_count got %0d want 6", n);
        end
    endtask

    task automatic test_redirect_drop();
        logic [31:0] exp_pc;
        int n;
        do_reset(3);
        instr_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (imem_req_valid !== 1'b0) begin
            errors++; $display("FAIL rd_credit_full got %b want 0", imem_req_valid);
        end
        redirect_valid = 1'b1; redirect_pc = 32'h100;
        #1;
        checks++;
        if (imem_req_valid !== 1'b0 || instr_valid !== 1'b0) begin
            errors++; $display("FAIL rd_cycle_quiet got req=%b instr=%b want 0 0", imem_req_valid, instr_valid);
        end
        @(negedge clk);
        redirect_valid = 1'b0;
        exp_pc = 32'h100; n = 0;
        for (int i = 0; i < 30 && n < 2; i++) begin
            #1;
            if (instr_valid) begin
                checks++;
                if (instr_pc !== exp_pc || instr !== ~exp_pc) begin
                    errors++; $display("FAIL rd_word got pc=%h d=%h want pc=%h d=%h", instr_pc, instr, exp_pc, ~exp_pc);
                end
                exp_pc += 32'd4; n++;
            end
            @(negedge clk);
        end
        checks++;
        if (n != 2) begin
            errors++; $display("FAIL rd_count got %0d want 2", n);
        end
    endtask

    task automatic test_redirect_same_cycle();
        logic [31:0] exp_pc;
        int n;
        do_reset(1);
        @(negedge clk);
        redirect_valid = 1'b1; redirect_pc = 32'h203;
        #1;
        checks++;
        if (imem_req_valid !== 1'b0) begin
            errors++; $display("FAIL sc_req_during_redirect got %b want 0", imem_req_valid);
        end
        @(negedge clk);
        redirect_valid = 1'b0;
        #1;
        checks++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h200) begin
            errors++; $display("FAIL sc_new_req got v=%b a=%h want v=1 a=00000200", imem_req_valid, imem_req_addr);
        end
        checks++;
        if (instr_valid !== 1'b0) begin
            errors++; $display("FAIL sc_rsp_discarded got instr_valid=%b want 0", instr_valid);
        end
        instr_ready = 1'b1;
        exp_pc = 32'h200; n = 0;
        for (int i = 0; i < 30 && n < 3; i++) begin
            #1;
            if (instr_valid) begin
                checks++;
                if (instr_pc !== exp_pc || instr !== ~exp_pc) begin
                    errors++; $display("FAIL sc_word got pc=%h d=%h want pc=%h d=%h", instr_pc, instr, exp_pc, ~exp_pc);
                end
                exp_pc += 32'd4; n++;
            end
            @(negedge clk);
        end
        checks++;
        if (n != 3) begin
            errors++; $display("FAIL sc_count got %0d want 3", n);
        end
    endtask

    task automatic test_req_stall();
        logic [31:0] exp_addr, exp_pc;
        do_reset(1);
        instr_ready = 1'b1;
        exp_addr = 32'h0; exp_pc = 32'h0;
        for (int i = 0; i < 40; i++) begin
            imem_req_ready = !(i >= 3 && i < 8);
            #1;
            if (imem_req_valid) begin
                checks++;
                if (imem_req_addr !== exp_addr) begin
                    errors++; $display("FAIL stall_addr cycle %0d got %h want %h", i, imem_req_addr, exp_addr);
                end
            end
            if (i >= 5 && i < 8) begin
                checks++;
                if (imem_req_valid !== 1'b1) begin
                    errors++; $display("FAIL stall_valid_held cycle %0d got %b want 1", i, imem_req_valid);
                end
            end
            if (imem_req_valid && imem_req_ready) exp_addr += 32'd4;
            if (instr_valid) begin
                checks++;
                if (instr_pc !== exp_pc || instr !== ~exp_pc) begin
                    errors++; $display("FAIL stall_word got pc=%h d=%h want pc=%h d=%h", instr_pc, instr, exp_pc, ~exp_pc);
                end
                exp_pc += 32'd4;
            end
            @(negedge clk);
        end
        imem_req_ready = 1'b1;
        checks++;
        if (exp_pc < 32'h20) begin
            errors++; $display("FAIL stall_progress got pc=%h want >= 00000020", exp_pc);
        end
    endtask

`ifdef SR_FETCH_PERF_EN
    task automatic test_perf();
        logic [31:0] exp_pc;
        int n;
        do_reset(3);
        repeat (4) @(negedge clk);
        #1;
        checks++;
        if (instr_valid !== 1'b1 || instr_pc !== 32'h0) begin
            errors++; $display("FAIL perf_setup got v=%b pc=%h want v=1 pc=00000000", instr_valid, instr_pc);
        end
        redirect_valid = 1'b1; redirect_pc = 32'h40;
        @(negedge clk);
        redirect_valid = 1'b0;
        instr_ready = 1'b1;
        exp_pc = 32'h40; n = 0;
        for (int i = 0; i < 80 && n < 10; i++) begin
            #1;
            if (instr_valid) begin
                checks++;
                if (instr_pc !== exp_pc) begin
                    errors++; $display("FAIL perf_word got pc=%h want %h", instr_pc, exp_pc);
                end
                exp_pc += 32'd4; n++;
            end
            @(negedge clk);
        end
        instr_ready = 1'b0;
        #1;
        checks++;
        if (perf_fetched !== 32'd10) begin
            errors++; $display("FAIL perf_fetched got %0d want 10", perf_fetched);
        end
        checks++;
        if (perf_dropped !== 32'd2) begin
            errors++; $display("FAIL perf_dropped got %0d want 2", perf_dropped);
        end
    endtask
`endif

    initial begin
        rst = 1'b1; imem_req_ready = 1'b0; redirect_valid = 1'b0;
        redirect_pc = 32'h0; instr_ready = 1'b0;
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_drop();
        test_redirect_same_cycle();
        test_req_stall();
`ifdef SR_FETCH_PERF_EN
        test_perf();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
